// File: rtl/wbdispatch_pkg.sv
// Shared types and constants for the Wishbone device dispatcher.
package wbdispatch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Read data returned for addresses that decode to no device slot.
   localparam int unsigned UNMAPPED_RDATA = 0;

endpackage

// File: rtl/wbdispatch.sv
// Registered Wishbone dispatcher: one requester fanned out to NUM_DEV device slots,
// with a per-transaction timeout watchdog and abort on requester cyc drop.
module wbdispatch
   import wbdispatch_pkg::*;
#(
   parameter int unsigned NUM_DEV    = 4,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SEL_BITS   = 8,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wb_stb_i,
   input  logic                           wb_cyc_i,
   input  logic                           wb_we_i,
   input  logic [ADDR_WIDTH-1:0]          wb_adr_i,
   input  logic [DATA_WIDTH-1:0]          wb_dat_i,
   output logic [DATA_WIDTH-1:0]          wb_dat_o,
   output logic                           wb_ack_o,
   output logic [NUM_DEV-1:0]             dev_wb_stb_o,
   output logic [NUM_DEV-1:0]             dev_wb_cyc_o,
   output logic                           dev_wb_we_o,
   output logic [ADDR_WIDTH-1:0]          dev_wb_adr_o,
   output logic [DATA_WIDTH-1:0]          dev_wb_dat_o,
   input  logic [NUM_DEV*DATA_WIDTH-1:0]  dev_wb_dat_i,
   input  logic [NUM_DEV-1:0]             dev_wb_ack_i,
   output logic [7:0]                     timeout_cnt
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_DEV-1:0]     stb_q, stb_d;
   logic                   ack_q, ack_d;
   logic [DATA_WIDTH-1:0]  rdat_q, rdat_d;
   logic                   we_q, we_d;
   logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
   logic [DATA_WIDTH-1:0]  wdat_q, wdat_d;
   logic [7:0]             tcnt_q, tcnt_d;

   logic [SEL_BITS-1:0]    sel;
   logic                   sel_ack;
   logic [DATA_WIDTH-1:0]  sel_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stb_q   <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stb_q   <= stb_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // The one-hot strobe register doubles as the latched slot index,
   // so acks and read data are qualified by it instead of a decoded index.
   always_comb begin
      sel     = wb_adr_i[ADDR_WIDTH-1 -: SEL_BITS];
      sel_ack = |(dev_wb_ack_i & stb_q);
      sel_dat = '0;
      for (int unsigned k = 0; k < NUM_DEV; k++) begin
         if (stb_q[k]) sel_dat = dev_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stb_d   = stb_q;
      ack_d   = 1'b0;
      rdat_d  = rdat_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      tcnt_d  = tcnt_q;

      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               adr_d  = wb_adr_i;
               wdat_d = wb_dat_i;
               we_d   = wb_we_i;
               if (32'(sel) >= NUM_DEV) begin
                  rdat_d  = DATA_WIDTH'(UNMAPPED_RDATA);
                  ack_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  for (int unsigned k = 0; k < NUM_DEV; k++) begin
                     stb_d[k] = (32'(sel) == k);
                  end
                  cnt_d   = '0;
                  state_d = WAIT;
               end
            end
         end

         WAIT: begin
            if (!wb_cyc_i) begin
               stb_d   = '0;
               state_d = IDLE;
            end else if (sel_ack) begin
               rdat_d  = sel_dat;
               stb_d   = '0;
               ack_d   = 1'b1;
               state_d = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rdat_d  = '1;
               stb_d   = '0;
               ack_d   = 1'b1;
               if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            stb_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign wb_dat_o     = rdat_q;
   assign wb_ack_o     = ack_q;
   assign dev_wb_stb_o = stb_q;
   assign dev_wb_cyc_o = stb_q;
   assign dev_wb_we_o  = we_q;
   assign dev_wb_adr_o = adr_q;
   assign dev_wb_dat_o = wdat_q;
   assign timeout_cnt  = tcnt_q;

endmodule

// File: tb/tb_wbdispatch.sv
// Directed bench for wbdispatch: vector table of single transactions plus
// hand-written reset, mid-WAIT reset and timeout-saturation sequences.
module tb_wbdispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_stb_i, wb_cyc_i, wb_we_i;
   logic [15:0] wb_adr_i;
   logic [7:0]  wb_dat_i;
   logic [7:0]  wb_dat_o;
   logic        wb_ack_o;
   logic [3:0]  dev_wb_stb_o, dev_wb_cyc_o;
   logic        dev_wb_we_o;
   logic [15:0] dev_wb_adr_o;
   logic [7:0]  dev_wb_dat_o;
   logic [31:0] dev_wb_dat_i;
   logic [3:0]  dev_wb_ack_i;
   logic [7:0]  timeout_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wbdispatch #(
      .NUM_DEV(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .SEL_BITS(8), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .dev_wb_stb_o(dev_wb_stb_o), .dev_wb_cyc_o(dev_wb_cyc_o),
      .dev_wb_we_o(dev_wb_we_o), .dev_wb_adr_o(dev_wb_adr_o),
      .dev_wb_dat_o(dev_wb_dat_o), .dev_wb_dat_i(dev_wb_dat_i),
      .dev_wb_ack_i(dev_wb_ack_i), .timeout_cnt(timeout_cnt)
   );

   typedef struct {
      logic [15:0] adr;
      logic        we;
      logic [7:0]  wdat;
      int          ack_at;     // WAIT cycle in which the device acks, 0 = silent
      logic [7:0]  ack_dat;
      int          abort_at;   // cycle in which cyc is dropped, 0 = never
      bit          noise;      // neighbouring slot acks every cycle before ack_at
      int          exp_ack;    // cycle of wb_ack_o, 0 = none
      logic [7:0]  exp_dat;
      logic [3:0]  exp_mask;
      int          exp_first;
      int          exp_last;
      logic [7:0]  exp_tcnt;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, output int ack_cyc, output int ack_cnt,
                          output logic [7:0] dat, output logic [3:0] mask,
                          output int first, output int last, output bit bus_ok);
      int dev;
      bit mapped;
      logic [31:0] dd;
      mapped  = (v.adr[15:8] < 8'd4);
      dev     = int'(v.adr[9:8]);
      ack_cyc = 0; ack_cnt = 0; mask = '0; first = 0; last = 0; bus_ok = 1'b1;
      dd = 32'h44332211;
      if (mapped) dd[dev*8 +: 8] = v.ack_dat;
      @(negedge clk);
      dev_wb_dat_i = dd;
      wb_adr_i = v.adr; wb_we_i = v.we; wb_dat_i = v.wdat;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      dat = wb_dat_o;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (wb_ack_o) begin
            ack_cnt++;
            if (ack_cyc == 0) begin
               ack_cyc = c;
               dat = wb_dat_o;
            end
            wb_cyc_i = 1'b0;
         end
         if (dev_wb_stb_o != 4'b0) begin
            mask |= dev_wb_stb_o;
            if (first == 0) first = c;
            last = c;
            if (dev_wb_cyc_o != dev_wb_stb_o || $countones(dev_wb_stb_o) != 1 ||
                dev_wb_adr_o != v.adr || dev_wb_we_o != v.we || dev_wb_dat_o != v.wdat)
               bus_ok = 1'b0;
         end
         wb_stb_i = 1'b0;
         if (c == v.abort_at) wb_cyc_i = 1'b0;
         dev_wb_ack_i = '0;
         if (mapped && c == v.ack_at) dev_wb_ack_i[dev] = 1'b1;
         else if (mapped && v.noise && c < v.ack_at) dev_wb_ack_i[(dev + 1) % 4] = 1'b1;
      end
      if (ack_cyc == 0) dat = wb_dat_o;
   endtask

   task automatic run_and_check(input vec_t v, input int idx);
      int ack_cyc, ack_cnt, first, last;
      logic [7:0] dat;
      logic [3:0] mask;
      bit bus_ok;
      run_txn(v, ack_cyc, ack_cnt, dat, mask, first, last, bus_ok);
      check($sformatf("v%0d ack_cycle", idx), ack_cyc, v.exp_ack);
      check($sformatf("v%0d ack_count", idx), ack_cnt, (v.exp_ack != 0) ? 1 : 0);
      check($sformatf("v%0d dat", idx), dat, v.exp_dat);
      check($sformatf("v%0d stb_mask", idx), mask, v.exp_mask);
      check($sformatf("v%0d stb_first", idx), first, v.exp_first);
      check($sformatf("v%0d stb_last", idx), last, v.exp_last);
      check($sformatf("v%0d dev_bus", idx), bus_ok, 1);
      check($sformatf("v%0d timeout_cnt", idx), timeout_cnt, v.exp_tcnt);
   endtask

   initial begin
      int ack_cyc, ack_cnt, first, last;
      logic [7:0] dat;
      logic [3:0] mask;
      bit bus_ok;
      vec_t tv;

      //          adr       we    wdat   ack ackdat abrt noise  exp_ack exp_dat mask  f  l  tcnt
      vecs[0] = '{16'h0512, 1'b0, 8'h00, 0, 8'h00, 0, 1'b0, 1, 8'h00, 4'b0000, 0, 0, 8'd0};
      vecs[1] = '{16'h0203, 1'b0, 8'h00, 1, 8'hA5, 0, 1'b0, 2, 8'hA5, 4'b0100, 1, 1, 8'd0};
      vecs[2] = '{16'h0110, 1'b1, 8'h3C, 5, 8'h77, 0, 1'b0, 6, 8'h77, 4'b0010, 1, 5, 8'd0};
      vecs[3] = '{16'h0000, 1'b0, 8'h00, 0, 8'h00, 0, 1'b0, 9, 8'hFF, 4'b0001, 1, 8, 8'd1};
      vecs[4] = '{16'h0000, 1'b0, 8'h00, 8, 8'h5A, 0, 1'b0, 9, 8'h5A, 4'b0001, 1, 8, 8'd1};
      vecs[5] = '{16'h0300, 1'b0, 8'h00, 3, 8'hC3, 0, 1'b1, 4, 8'hC3, 4'b1000, 1, 3, 8'd1};
      vecs[6] = '{16'h0100, 1'b0, 8'h00, 0, 8'h00, 3, 1'b0, 0, 8'hC3, 4'b0010, 1, 3, 8'd1};
      vecs[7] = '{16'hFF00, 1'b1, 8'h99, 0, 8'h00, 0, 1'b0, 1, 8'h00, 4'b0000, 0, 0, 8'd1};

      rst = 1'b1;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0;
      dev_wb_dat_i = '0; dev_wb_ack_i = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset outputs",
            {wb_dat_o, wb_ack_o, dev_wb_stb_o, dev_wb_cyc_o, dev_wb_we_o,
             dev_wb_adr_o[6:0]}, 32'h0);
      check("reset bus", {dev_wb_adr_o, dev_wb_dat_o, timeout_cnt}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_and_check(vecs[i], i);

      // reset asserted in the third WAIT cycle of a read
      @(negedge clk);
      dev_wb_dat_i = 32'h44332211;
      wb_adr_i = 16'h0203; wb_we_i = 1'b0; wb_dat_i = 8'h00;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      @(negedge clk);
      wb_stb_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midwait stb before reset", dev_wb_stb_o, 4'b0100);
      #1 rst = 1'b1;
      #1;
      check("midwait reset ctl",
            {wb_dat_o, wb_ack_o, dev_wb_stb_o, dev_wb_cyc_o, dev_wb_we_o}, 32'h0);
      check("midwait reset bus", {dev_wb_adr_o, dev_wb_dat_o, timeout_cnt}, 32'h0);
      @(negedge clk);
      wb_cyc_i = 1'b0;
      rst = 1'b0;

      tv = vecs[1];
      tv.exp_tcnt = 8'd0;
      run_and_check(tv, 8);

      // 300 silent-device timeouts saturate the counter at 255
      tv = vecs[3];
      for (int n = 0; n < 300; n++) begin
         run_txn(tv, ack_cyc, ack_cnt, dat, mask, first, last, bus_ok);
      end
      check("sat ack_cycle", ack_cyc, 9);
      check("sat dat", dat, 8'hFF);
      check("sat timeout_cnt", timeout_cnt, 8'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
